// File: rtl/escalonador_colisao_if.sv
// Bus bundle for the collision sequencer: game-FSM start/done handshake plus
// the synchronous asteroid RAM read port.
//
// Handshake: `iniciar` is a request that is accepted only on a clock edge
// where the sequencer is idle (`ocupado`=0). Requests at any other time are
// dropped, never queued. `pronto` is a one-cycle completion strobe, and
// `colisao`/`colisao_idx` are valid from then until the next accepted
// request. The RAM port has no handshake: `ast_*` data returns exactly one
// cycle after `ast_addr` is presented.
interface escalonador_colisao_if #(
    parameter int W = 10,
    parameter int A = 3
);
    logic         iniciar;
    logic [W-1:0] tiro_x;
    logic [W-1:0] tiro_y;
    logic [A-1:0] ast_addr;
    logic [W-1:0] ast_x;
    logic [W-1:0] ast_y;
    logic         ast_ativo;
    logic         ocupado;
    logic         pronto;
    logic         colisao;
    logic [A-1:0] colisao_idx;

    modport slave (
        input  iniciar, tiro_x, tiro_y, ast_x, ast_y, ast_ativo,
        output ast_addr, ocupado, pronto, colisao, colisao_idx
    );

    modport master (
        output iniciar, tiro_x, tiro_y, ast_x, ast_y, ast_ativo,
        input  ast_addr, ocupado, pronto, colisao, colisao_idx
    );
endinterface

// File: rtl/escalonador_colisao.sv
// Walks the asteroid table and tests the latched shot against each slot's
// bounding box, using one shared (W+1)-bit comparator, one bound per cycle.
module escalonador_colisao #(
    parameter int W = 10,
    parameter int M = 8,
    parameter int A = 3,
    parameter int L = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    escalonador_colisao_if.slave    bus,
    output logic [2:0]              estado_dbg
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, CMP_XLO, CMP_XHI, CMP_YLO, CMP_YHI, DONE
    } estado_t;

    localparam logic [A-1:0] ULTIMO = A'(M - 1);
    localparam logic [W:0]   LADO   = (W + 1)'(L);

    estado_t      state_q, state_d;
    logic [A-1:0] i_q, i_d;
    logic [A-1:0] addr_q, addr_d;
    logic [W-1:0] tiro_x_q, tiro_x_d;
    logic [W-1:0] tiro_y_q, tiro_y_d;
    logic [W-1:0] ast_x_q, ast_x_d;
    logic [W-1:0] ast_y_q, ast_y_d;
    logic         colisao_q, colisao_d;
    logic [A-1:0] idx_q, idx_d;

    logic [W:0]   cmp_a, cmp_b;
    logic         cmp_ge;
    logic         pular;

    // Operand select for the shared comparator; upper bounds are formed at
    // W+1 bits so a box near the right/bottom edge never wraps around.
    always_comb begin
        cmp_a = {1'b0, tiro_x_q};
        cmp_b = {1'b0, ast_x_q};
        case (state_q)
            CMP_XHI: cmp_b = {1'b0, ast_x_q} + LADO;
            CMP_YLO: begin
                cmp_a = {1'b0, tiro_y_q};
                cmp_b = {1'b0, ast_y_q};
            end
            CMP_YHI: begin
                cmp_a = {1'b0, tiro_y_q};
                cmp_b = {1'b0, ast_y_q} + LADO;
            end
            default: ;
        endcase
    end

    assign cmp_ge = (cmp_a >= cmp_b);

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        addr_d    = addr_q;
        tiro_x_d  = tiro_x_q;
        tiro_y_d  = tiro_y_q;
        ast_x_d   = ast_x_q;
        ast_y_d   = ast_y_q;
        colisao_d = colisao_q;
        idx_d     = idx_q;
        pular     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.iniciar) begin
                    tiro_x_d  = bus.tiro_x;
                    tiro_y_d  = bus.tiro_y;
                    i_d       = '0;
                    addr_d    = '0;
                    colisao_d = 1'b0;
                    idx_d     = '0;
                    state_d   = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                ast_x_d = bus.ast_x;
                ast_y_d = bus.ast_y;
                if (bus.ast_ativo) state_d = CMP_XLO;
                else               pular   = 1'b1;
            end
            CMP_XLO: if (cmp_ge)  state_d = CMP_XHI; else pular = 1'b1;
            CMP_XHI: if (!cmp_ge) state_d = CMP_YLO; else pular = 1'b1;
            CMP_YLO: if (cmp_ge)  state_d = CMP_YHI; else pular = 1'b1;
            CMP_YHI: begin
                if (!cmp_ge) begin
                    colisao_d = 1'b1;
                    idx_d     = i_q;
                    state_d   = DONE;
                end else begin
                    pular = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The address register is loaded on entry to FETCH so it is already
        // on the RAM port for the whole FETCH cycle.
        if (pular) begin
            if (i_q == ULTIMO) begin
                state_d = DONE;
            end else begin
                i_d     = i_q + 1'b1;
                addr_d  = i_q + 1'b1;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            addr_q    <= '0;
            tiro_x_q  <= '0;
            tiro_y_q  <= '0;
            ast_x_q   <= '0;
            ast_y_q   <= '0;
            colisao_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            addr_q    <= addr_d;
            tiro_x_q  <= tiro_x_d;
            tiro_y_q  <= tiro_y_d;
            ast_x_q   <= ast_x_d;
            ast_y_q   <= ast_y_d;
            colisao_q <= colisao_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.ast_addr    = addr_q;
    assign bus.ocupado     = (state_q != IDLE);
    assign bus.pronto      = (state_q == DONE);
    assign bus.colisao     = colisao_q;
    assign bus.colisao_idx = idx_q;
    assign estado_dbg      = state_q;

endmodule

// File: tb/tb_escalonador_colisao.sv
// Bench for escalonador_colisao: synchronous RAM model, spec-level reference
// scan, directed and randomized scans.
module tb_escalonador_colisao;
  localparam int W = 10;
  localparam int M = 8;
  localparam int A = 3;
  localparam int L = 16;

  logic       clock;
  logic       reset_n;
  logic [2:0] estado_dbg;

  int vectors;
  int miscompares;

  logic [W-1:0] mem_x [M];
  logic [W-1:0] mem_y [M];
  logic         mem_a [M];

  escalonador_colisao_if #(.W(W), .A(A)) bus ();

  escalonador_colisao #(.W(W), .M(M), .A(A), .L(L)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .estado_dbg (estado_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // synchronous asteroid RAM: data one cycle after the address
  always @(posedge clock) begin
    bus.ast_x     <= mem_x[bus.ast_addr];
    bus.ast_y     <= mem_y[bus.ast_addr];
    bus.ast_ativo <= mem_a[bus.ast_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_table();
    for (int s = 0; s < M; s++) begin
      mem_x[s] = '0;
      mem_y[s] = '0;
      mem_a[s] = 1'b0;
    end
  endtask

  task automatic set_slot(input int s, input int x, input int y, input logic a);
    mem_x[s] = W'(x);
    mem_y[s] = W'(y);
    mem_a[s] = a;
  endtask

  // Reference: box test with unbounded integer arithmetic, cycle cost per slot
  // by how far the four bounds get, first hit wins.
  function automatic void ref_scan(input int tx, input int ty,
                                   output logic hit, output int idx, output int cyc);
    hit = 1'b0;
    idx = 0;
    cyc = 2;
    for (int s = 0; s < M; s++) begin
      if (!mem_a[s])                        cyc += 2;
      else if (tx <  int'(mem_x[s]))        cyc += 3;
      else if (tx >= int'(mem_x[s]) + L)    cyc += 4;
      else if (ty <  int'(mem_y[s]))        cyc += 5;
      else if (ty >= int'(mem_y[s]) + L)    cyc += 6;
      else begin
        cyc += 6;
        hit = 1'b1;
        idx = s;
        break;
      end
    end
  endfunction

  // driver + checker for one complete scan
  task automatic run_scan(input logic [W-1:0] tx, input logic [W-1:0] ty,
                          input bit noise, input string tag);
    logic exp_hit;
    int   exp_idx, exp_cyc, exp_last, cyc, max_addr;
    logic seen;
    ref_scan(int'(tx), int'(ty), exp_hit, exp_idx, exp_cyc);
    exp_last = exp_hit ? exp_idx : M - 1;
    @(negedge clock);
    bus.tiro_x  = tx;
    bus.tiro_y  = ty;
    bus.iniciar = 1'b1;
    cyc      = 1;
    max_addr = 0;
    seen     = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (int'(bus.ast_addr) > max_addr) max_addr = int'(bus.ast_addr);
      if (bus.pronto) begin
        seen = 1'b1;
        break;
      end
      bus.iniciar = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    bus.iniciar = 1'b0;
    chk({tag, " pronto_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " colisao"}, 32'(bus.colisao), 32'(exp_hit));
    chk({tag, " colisao_idx"}, 32'(bus.colisao_idx), 32'(exp_idx));
    chk({tag, " last_addr"}, 32'(max_addr), 32'(exp_last));
    chk({tag, " ocupado_done"}, 32'(bus.ocupado), 32'd1);
    @(negedge clock);
    chk({tag, " pronto_pulse"}, 32'(bus.pronto), 32'd0);
    chk({tag, " ocupado_idle"}, 32'(bus.ocupado), 32'd0);
    chk({tag, " colisao_hold"}, 32'(bus.colisao), 32'(exp_hit));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ast_addr"}, 32'(bus.ast_addr), 32'd0);
    chk({tag, " ocupado"}, 32'(bus.ocupado), 32'd0);
    chk({tag, " pronto"}, 32'(bus.pronto), 32'd0);
    chk({tag, " colisao"}, 32'(bus.colisao), 32'd0);
    chk({tag, " colisao_idx"}, 32'(bus.colisao_idx), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    int           k;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    bus.iniciar = 1'b0;
    bus.tiro_x  = '0;
    bus.tiro_y  = '0;
    clear_table();

    // power-on reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("por");
    reset_n = 1'b1;

    // single hit in slot 3
    clear_table();
    set_slot(3, 100, 200, 1'b1);
    run_scan(10'd110, 10'd215, 1'b0, "single_hit");

    // box edges, slot 0 only
    clear_table();
    set_slot(0, 100, 200, 1'b1);
    run_scan(10'd115, 10'd215, 1'b0, "edge_hi_in");
    run_scan(10'd116, 10'd215, 1'b0, "edge_x_out");
    run_scan(10'd115, 10'd216, 1'b0, "edge_y_out");
    run_scan(10'd100, 10'd200, 1'b0, "edge_lo_in");
    run_scan(10'd99,  10'd200, 1'b0, "edge_lo_out");

    // first-hit priority
    clear_table();
    for (int s = 0; s < M; s++) set_slot(s, 600, 600, 1'b1);
    set_slot(2, 300, 400, 1'b1);
    set_slot(5, 300, 400, 1'b1);
    run_scan(10'd305, 10'd405, 1'b0, "priority");

    // worst case: all active, every slot fails on the Y upper bound, with
    // start pulses thrown in during the scan
    clear_table();
    for (int s = 0; s < M; s++) set_slot(s, 100, 200, 1'b1);
    run_scan(10'd110, 10'd216, 1'b1, "no_hit_worst");

    // right-edge box must not wrap its upper bound
    clear_table();
    set_slot(4, 1023, 50, 1'b1);
    run_scan(10'd5,    10'd55, 1'b0, "ovf_miss");
    run_scan(10'd1023, 10'd55, 1'b0, "ovf_hit");

    // reset during a compare: leave a prior hit result, then abort mid-scan
    clear_table();
    set_slot(0, 100, 200, 1'b1);
    set_slot(6, 300, 300, 1'b1);
    run_scan(10'd305, 10'd305, 1'b0, "pre_reset");
    @(negedge clock);
    bus.tiro_x  = 10'd110;
    bus.tiro_y  = 10'd210;
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("mid_reset");
    reset_n = 1'b1;
    run_scan(10'd110, 10'd210, 1'b0, "post_reset");

    // randomized tables and shots, biased toward hitting some slot
    for (int n = 0; n < 20; n++) begin
      for (int s = 0; s < M; s++)
        set_slot(s, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)));
      k  = int'($urandom_range(0, M - 1));
      rx = W'(int'(mem_x[k]) + int'($urandom_range(0, 20)) - 2);
      ry = W'(int'(mem_y[k]) + int'($urandom_range(0, 20)) - 2);
      run_scan(rx, ry, 1'($urandom_range(0, 1)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/escalonador_colisao.md
# escalonador_colisao

Sequencer that time-shares one magnitude comparator to test a shot position against every asteroid slot in the game's asteroid table. On `iniciar` it walks slots 0..M-1, reads each slot from the synchronous asteroid RAM, and performs up to four bounding-box comparisons per slot, one per cycle. It stops at the first hit and reports the slot index. It sits between the game FSM (start/done handshake) and the asteroid RAM (address out, data back one cycle later).

## Interface

- `W`, 10, coordinate width in bits
- `M`, 8, number of asteroid slots (1 ≤ M ≤ 2^A)
- `A`, 3, slot address width
- `L`, 16, asteroid box side in pixels (1 ≤ L < 2^W)

- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `iniciar`  in  1  start pulse; sampled only in IDLE
- `tiro_x`  in  W  shot X; latched on accepted start
- `tiro_y`  in  W  shot Y; latched on accepted start
- `ast_addr`  out  A  asteroid RAM read address
- `ast_x`  in  W  slot X origin; valid the cycle after `ast_addr`
- `ast_y`  in  W  slot Y origin; same timing as `ast_x`
- `ast_ativo`  in  1  slot occupied flag; same timing as `ast_x`
- `ocupado`  out  1  high from the cycle after an accepted start through DONE
- `pronto`  out  1  one-cycle pulse when the scan finishes
- `colisao`  out  1  hit result of the last scan
- `colisao_idx`  out  A  index of the first hit slot; 0 if no hit

## Operation

- States: IDLE, FETCH, LOAD, CMP_XLO, CMP_XHI, CMP_YLO, CMP_YHI, DONE.
- IDLE: on `iniciar`=1, do the following and go to FETCH:
  - latch `tiro_x` and `tiro_y`
  - clear the slot counter `i`, `colisao` and `colisao_idx`
- FETCH: drive `ast_addr`=i, go to LOAD.
- LOAD: register `ast_x`, `ast_y` and `ast_ativo`.
  - If `ast_ativo`=0, the slot is skipped.
  - Otherwise go to CMP_XLO.
- Compare states use one shared comparator at width W+1, with both operands zero-extended. Upper bounds `ast_x+L` and `ast_y+L` are computed at W+1 bits, so they never wrap.
  - CMP_XLO: pass if `tiro_x ≥ ast_x`.
  - CMP_XHI: pass if `tiro_x < ast_x+L`.
  - CMP_YLO: pass if `tiro_y ≥ ast_y`.
  - CMP_YHI: pass if `tiro_y < ast_y+L`.
- On pass, go to the next compare state.
- On any fail, the slot is skipped.
- Pass in CMP_YHI is a hit: set `colisao`=1 and `colisao_idx`=i, then go to DONE. Remaining slots are not scanned.
- Skip rule:
  - If i = M-1, go to DONE with `colisao`=0.
  - Otherwise i ← i+1 and go to FETCH.
- DONE: assert `pronto` for one cycle, go to IDLE.
- `colisao` and `colisao_idx` hold until the next accepted start.
- `iniciar` outside IDLE is ignored; a start is never queued.

## Timing

- Reset (`reset_n`=0 at an edge), from any state including mid-scan, yields all of:
  - state IDLE, i=0
  - `ast_addr`=0, `ocupado`=0, `pronto`=0
  - `colisao`=0, `colisao_idx`=0
  - latched shot cleared to 0
- `ast_addr` outside FETCH holds the last value driven.
- Per-slot cost, counted from FETCH:
  - inactive slot: 2 cycles
  - fail at CMP_XLO: 3; at CMP_XHI: 4; at CMP_YLO: 5; at CMP_YHI: 6
  - hit: 6
- `pronto` rises one cycle after the last compare or LOAD cycle. Total latency from the `iniciar` edge equals:
  - the sum of the per-slot costs
  - plus 1 cycle for the IDLE→FETCH transition
  - plus 1 cycle for DONE
- Worst case (no hit, every slot failing at CMP_YHI): 6M+2 cycles.
- `iniciar`=1 in DONE is ignored. It is accepted if still high in the following IDLE cycle, so back-to-back scans have a minimum 1-cycle IDLE gap.
- Boundaries:
  - `tiro_x`=`ast_x` is inside the box.
  - `tiro_x`=`ast_x+L-1` is inside the box.
  - `tiro_x`=`ast_x+L` is outside the box.
  - Y follows the same rules.
  - With `ast_x`=2^W-1, the upper bound is 2^W-1+L at W+1 bits; no false pass.
- M=1: exactly one slot is scanned; i never increments.

## Test plan

- Reset mid-scan: assert `reset_n`=0 while in CMP_XHI → next cycle all outputs 0, state IDLE; a new `iniciar` starts from slot 0.
- Single hit, W=10, M=8, L=16: slot 3 active at (100,200), others inactive, shot (110,215) → `colisao`=1, `colisao_idx`=3, `pronto` 2+2+2+6+1+1 = 14 cycles after the start edge.
- Edge inclusivity: slot 0 at (100,200):
  - shot (115,215) → hit.
  - shot (116,215) → miss.
  - shot (100,200) → hit.
- First-hit priority: slots 2 and 5 both contain the shot → `colisao_idx`=2, slot 5 never addressed.
- No hit, all 8 slots active, each failing at CMP_YHI → `colisao`=0, `colisao_idx`=0, `pronto` at 6·8+2 = 50 cycles; `iniciar` pulses during the scan are ignored.
- Overflow: slot at x=1023, L=16, shot x=5 → miss (upper bound 1039 at 11 bits, no wrap to 15).
